// File: rtl/spec_integrator_if.sv
// Streaming interface between the spectrum source, the integrator and the
// capture buffer: power samples in, integrated bursts and status flags out.
interface spec_integrator_if #(
   parameter int IN_W = 24
) ();
   logic [IN_W-1:0] din;
   logic            din_valid;
   logic            din_sof;
   logic [15:0]     data_out;
   logic            en_sync_out;
   logic            err_flag;
   logic            sat_flag;

   // Source / capture side
   modport master (
      output din, din_valid, din_sof,
      input  data_out, en_sync_out, err_flag, sat_flag
   );

   // Integrator side
   modport slave (
      input  din, din_valid, din_sof,
      output data_out, en_sync_out, err_flag, sat_flag
   );
endinterface

// File: rtl/spec_integrator.sv
// Power spectrum integrator: accumulates ACC_LEN frames of FRAME_LEN bins in a
// block RAM and emits one contiguous burst of scaled, saturated 16-bit words
// during the final frame of every integration.
module spec_integrator #(
   parameter int BITWIDTH  = 7,
   parameter int FFT_POINT = 512,
   parameter int IN_W      = 24,
   parameter int ACC_LEN   = 16,
   parameter int SHIFT     = 12
) (
   input  logic              clk,
   input  logic              rst,
   spec_integrator_if.slave  bus
);
   localparam int FRAME_LEN = 4 * FFT_POINT;
   localparam int AW        = BITWIDTH + 4;
   localparam int FW        = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam int ACC_W     = IN_W + FW;

   localparam logic [AW-1:0] LAST_BIN = AW'(FRAME_LEN - 1);
   localparam logic [FW-1:0] LAST_FRM = FW'(ACC_LEN - 1);

   localparam logic [0:0] ST_WAIT_SOF = 1'b0;
   localparam logic [0:0] ST_RUN      = 1'b1;

   // Parameter sanity: frame counter wraps by overflow, RAM is fully addressed
   if (ACC_LEN < 2 || (ACC_LEN & (ACC_LEN - 1)) != 0) begin : g_bad_acc_len
      $error("spec_integrator: ACC_LEN must be a power of 2 and at least 2");
   end
   if ((1 << AW) != FRAME_LEN) begin : g_bad_addr_w
      $error("spec_integrator: BITWIDTH+4 must equal log2(4*FFT_POINT)");
   end

   // Framing state
   logic [0:0]      state_reg, state_next;
   logic [AW-1:0]   bin_cnt_reg, bin_cnt_next;
   logic [FW-1:0]   frm_cnt_reg, frm_cnt_next;

   // Stage-1 decode of the incoming sample
   logic            accept;
   logic [AW-1:0]   rd_addr;
   logic [FW-1:0]   smp_frm;
   logic            err_now;

   // Stage-1 pipeline registers
   logic            s1_valid_reg;
   logic            s1_first_reg;
   logic            s1_final_reg;
   logic [AW-1:0]   s1_addr_reg;
   logic [IN_W-1:0] s1_din_reg;

   // Accumulator RAM
   logic [ACC_W-1:0] acc_ram [FRAME_LEN];
   logic [ACC_W-1:0] rd_data_reg;

   // Stage-2 arithmetic
   logic [ACC_W-1:0]    sum;
   logic [ACC_W-1:0]    wr_data;
   logic [ACC_W+15:0]   scaled;
   logic                clip;
   logic [15:0]         word;
   logic                emit;

   // Output registers
   logic [15:0]     data_out_reg;
   logic            en_sync_out_reg;
   logic            err_flag_reg;
   logic            sat_flag_reg;

   // Framing FSM: picks the bin address and frame slot for each sample, flags errors
   always_comb begin
      state_next   = state_reg;
      bin_cnt_next = bin_cnt_reg;
      frm_cnt_next = frm_cnt_reg;
      accept       = 1'b0;
      rd_addr      = bin_cnt_reg;
      smp_frm      = frm_cnt_reg;
      err_now      = 1'b0;
      case (state_reg)
         ST_WAIT_SOF: begin
            if (bus.din_valid && bus.din_sof) begin
               accept       = 1'b1;
               rd_addr      = '0;
               bin_cnt_next = AW'(1);
               state_next   = ST_RUN;
            end
         end
         default: begin
            if (!bus.din_valid) begin
               // Frame broke off early: abandon the integration
               err_now      = 1'b1;
               state_next   = ST_WAIT_SOF;
               bin_cnt_next = '0;
               frm_cnt_next = '0;
            end else if (bus.din_sof) begin
               // Early start of frame: this sample is bin 0 of a fresh integration
               err_now      = 1'b1;
               accept       = 1'b1;
               rd_addr      = '0;
               smp_frm      = '0;
               bin_cnt_next = AW'(1);
               frm_cnt_next = '0;
            end else begin
               accept = 1'b1;
               if (bin_cnt_reg == LAST_BIN) begin
                  state_next   = ST_WAIT_SOF;
                  bin_cnt_next = '0;
                  frm_cnt_next = frm_cnt_reg + FW'(1);
               end else begin
                  bin_cnt_next = bin_cnt_reg + AW'(1);
               end
            end
         end
      endcase
   end

   // Framing state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_WAIT_SOF;
         bin_cnt_reg <= '0;
         frm_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         bin_cnt_reg <= bin_cnt_next;
         frm_cnt_reg <= frm_cnt_next;
      end
   end

   // Stage-1 control: only the valid bit needs a reset
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
      end else begin
         s1_valid_reg <= accept;
      end
   end

   // Stage-1 data: sample, bin index and frame role travel alongside the RAM read
   always_ff @(posedge clk) begin
      s1_addr_reg  <= rd_addr;
      s1_din_reg   <= bus.din;
      s1_first_reg <= (smp_frm == '0);
      s1_final_reg <= (smp_frm == LAST_FRM);
   end

   // RAM read port, registered, addressed by the arriving bin
   always_ff @(posedge clk) begin
      rd_data_reg <= acc_ram[rd_addr];
   end

   // RAM write port: write-back of the previous bin never collides with the read
   always_ff @(posedge clk) begin
      if (s1_valid_reg) begin
         acc_ram[s1_addr_reg] <= wr_data;
      end
   end

   // Accumulate, scale and saturate
   always_comb begin
      sum     = rd_data_reg + ACC_W'(s1_din_reg);
      wr_data = s1_first_reg ? ACC_W'(s1_din_reg) : sum;
      scaled  = {16'd0, sum} >> SHIFT;
      clip    = |scaled[ACC_W+15:16];
      word    = clip ? 16'hFFFF : scaled[15:0];
      // A framing error in this cycle cuts any burst in progress
      emit    = s1_valid_reg && s1_final_reg && !err_now;
   end

   // Output registers: burst data/enable, error pulse, sticky saturation
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out_reg    <= '0;
         en_sync_out_reg <= 1'b0;
         err_flag_reg    <= 1'b0;
         sat_flag_reg    <= 1'b0;
      end else begin
         data_out_reg    <= emit ? word : 16'd0;
         en_sync_out_reg <= emit;
         err_flag_reg    <= err_now;
         if (emit && clip) begin
            sat_flag_reg <= 1'b1;
         end
      end
   end

   assign bus.data_out    = data_out_reg;
   assign bus.en_sync_out = en_sync_out_reg;
   assign bus.err_flag    = err_flag_reg;
   assign bus.sat_flag    = sat_flag_reg;

endmodule
